// File: rtl/seq_addsub.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per cycle over NCH cycles,
// then publishes the result, carry-out and signed overflow on the completion edge.
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   a_ch, b_ch, sum_ch;
    logic               c_out;
    int                 k;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_ch    = '0;
        b_ch    = '0;
        sum_ch  = '0;
        c_out   = 1'b0;
        k       = int'(cnt_q);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // mode and cin are folded into the inverted operand and the initial carry
                    a_d     = in1;
                    b_d     = in2 ^ {WIDTH{mode}};
                    carry_d = cin ^ mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
                {c_out, sum_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
                res_d[k*CHUNK +: CHUNK] = sum_ch;
                carry_d = c_out;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NCH - 1)) begin
                    s_d     = res_d;
                    cout_d  = c_out;
                    // carry into the MSB is recovered from the MSB sum bit and its operands
                    ovf_d   = (sum_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1]) ^ c_out;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: three instances (CHUNK = 4, 1, 8) driven one at a time,
// expected results queued at issue time and compared when done rises.
module tb_seq_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v, mode_v, cin_v;
    logic [7:0] in1_v [3];
    logic [7:0] in2_v [3];
    wire  [2:0] busy_w, done_w, cout_w, ovf_w;
    wire  [7:0] s_w [3];

    seq_addsub #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]), .cin(cin_v[0]),
        .in1(in1_v[0]), .in2(in2_v[0]), .busy(busy_w[0]), .done(done_w[0]),
        .S(s_w[0]), .Cout(cout_w[0]), .ovf(ovf_w[0]));
    seq_addsub #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]), .cin(cin_v[1]),
        .in1(in1_v[1]), .in2(in2_v[1]), .busy(busy_w[1]), .done(done_w[1]),
        .S(s_w[1]), .Cout(cout_w[1]), .ovf(ovf_w[1]));
    seq_addsub #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]), .cin(cin_v[2]),
        .in1(in1_v[2]), .in2(in2_v[2]), .busy(busy_w[2]), .done(done_w[2]),
        .S(s_w[2]), .Cout(cout_w[2]), .ovf(ovf_w[2]));

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    typedef struct packed {
        logic       m;
        logic       ci;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   nch_of [3] = '{2, 8, 1};

    function automatic exp_t model(logic m, logic ci, logic [7:0] a, logic [7:0] b);
        logic [7:0] bw;
        logic [8:0] f;
        exp_t       e;
        bw  = b ^ {8{m}};
        f   = {1'b0, a} + {1'b0, bw} + {8'd0, ci ^ m};
        e.s = f[7:0];
        e.c = f[8];
        e.o = (a[7] == bw[7]) && (f[7] != a[7]);
        return e;
    endfunction

    // Drives one start cycle; returns just after the accepting edge.
    task automatic issue(int d, logic m, logic ci, logic [7:0] a, logic [7:0] b);
        mode_v[d]  = m;
        cin_v[d]   = ci;
        in1_v[d]   = a;
        in2_v[d]   = b;
        start_v[d] = 1'b1;
        sb.push_back(model(m, ci, a, b));
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        in1_v[d]   = 8'($urandom);
        in2_v[d]   = 8'($urandom);
        mode_v[d]  = 1'($urandom);
        cin_v[d]   = 1'($urandom);
    endtask

    task automatic wait_done(int d, output int cyc);
        cyc = 0;
        while (cyc < 40 && done_w[d] !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start_v = '0; mode_v = '0; cin_v = '0;
        for (int d = 0; d < 3; d++) begin
            in1_v[d] = '0;
            in2_v[d] = '0;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({busy_w[d], done_w[d], s_w[d], cout_w[d], ovf_w[d]} !== 12'h000) begin
                errors++;
                $display("FAIL reset[%0d] busy=%b done=%b S=%h Cout=%b ovf=%b, required all 0",
                         d, busy_w[d], done_w[d], s_w[d], cout_w[d], ovf_w[d]);
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        vec_t v [7] = '{
            '{1'b0, 1'b0, 8'h80, 8'h81}, '{1'b0, 1'b0, 8'h6A, 8'h07},
            '{1'b0, 1'b0, 8'h7F, 8'h0D}, '{1'b0, 1'b1, 8'hFF, 8'h00},
            '{1'b1, 1'b0, 8'h05, 8'h07}, '{1'b1, 1'b1, 8'h2F, 8'h01},
            '{1'b1, 1'b0, 8'h80, 8'h01}};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 7; i++) begin
            issue(0, v[i].m, v[i].ci, v[i].a, v[i].b);
            checks++;
            if (busy_w[0] !== 1'b1) begin
                errors++;
                $display("FAIL busy_run[%0d] got %b required 1", i, busy_w[0]);
            end
            wait_done(0, cyc);
            e = sb.pop_front();
            checks++;
            if (cyc != 2 || {s_w[0], cout_w[0], ovf_w[0], busy_w[0]} !== {e.s, e.c, e.o, 1'b0}) begin
                errors++;
                $display("FAIL op[%0d] lat=%0d S=%h Cout=%b ovf=%b busy=%b, required lat=2 S=%h Cout=%b ovf=%b busy=0",
                         i, cyc, s_w[0], cout_w[0], ovf_w[0], busy_w[0], e.s, e.c, e.o);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done_w[0] !== 1'b0 || s_w[0] !== e.s) begin
                errors++;
                $display("FAIL done_pulse[%0d] done=%b S=%h, required done=0 S=%h", i, done_w[0], s_w[0], e.s);
            end
        end
    endtask

    task automatic test_hold();
        exp_t prev, e;
        int   cyc;
        issue(0, 1'b0, 1'b1, 8'h12, 8'h34);
        wait_done(0, cyc);
        prev = sb.pop_front();
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 8'h00, 8'h01);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({s_w[0], cout_w[0], ovf_w[0]} !== {prev.s, prev.c, prev.o}) begin
                errors++;
                $display("FAIL hold[%0d] S=%h Cout=%b ovf=%b, required S=%h Cout=%b ovf=%b",
                         i, s_w[0], cout_w[0], ovf_w[0], prev.s, prev.c, prev.o);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done(0, cyc);
        e = sb.pop_front();
        checks++;
        if ({s_w[0], cout_w[0], ovf_w[0]} !== {e.s, e.c, e.o}) begin
            errors++;
            $display("FAIL hold_next S=%h Cout=%b ovf=%b, required S=%h Cout=%b ovf=%b",
                     s_w[0], cout_w[0], ovf_w[0], e.s, e.c, e.o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   pulses = 0;
        logic [7:0] s_at_done = '0;
        issue(0, 1'b0, 1'b0, 8'h11, 8'h22);
        mode_v[0] = 1'b1; cin_v[0] = 1'b1; in1_v[0] = 8'hF0; in2_v[0] = 8'h0F;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done_w[0] === 1'b1) begin
                pulses++;
                s_at_done = s_w[0];
            end
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        checks++;
        if (pulses != 1 || s_at_done !== e.s) begin
            errors++;
            $display("FAIL ignore_start pulses=%0d S=%h, required pulses=1 S=%h", pulses, s_at_done, e.s);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        int   bad = 0;
        issue(0, 1'b0, 1'b1, 8'h7F, 8'h7F);
        void'(sb.pop_front());
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_w[0], done_w[0], s_w[0], cout_w[0], ovf_w[0]} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b S=%h Cout=%b ovf=%b, required all 0",
                     busy_w[0], done_w[0], s_w[0], cout_w[0], ovf_w[0]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done_w[0] !== 1'b0 || s_w[0] !== 8'h00) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet bad_cycles=%0d, required 0", bad);
        end
        issue(0, 1'b0, 1'b0, 8'h6A, 8'h07);
        wait_done(0, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != 2 || s_w[0] !== e.s || cout_w[0] !== e.c) begin
            errors++;
            $display("FAIL reset_mid_next lat=%0d S=%h Cout=%b, required lat=2 S=%h Cout=%b",
                     cyc, s_w[0], cout_w[0], e.s, e.c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        issue(1, 1'b0, 1'b0, 8'hFF, 8'h01);
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != nch_of[1] || {s_w[1], cout_w[1], ovf_w[1]} !== {e.s, e.c, e.o}) begin
            errors++;
            $display("FAIL chunk1 lat=%0d S=%h Cout=%b ovf=%b, required lat=8 S=%h Cout=%b ovf=%b",
                     cyc, s_w[1], cout_w[1], ovf_w[1], e.s, e.c, e.o);
        end
        issue(1, 1'b0, 1'b0, 8'h40, 8'h40);
        checks++;
        if (busy_w[1] !== 1'b1 || done_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy busy=%b done=%b, required busy=1 done=0", busy_w[1], done_w[1]);
        end
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != nch_of[1] || {s_w[1], cout_w[1], ovf_w[1]} !== {e.s, e.c, e.o}) begin
            errors++;
            $display("FAIL b2b_result lat=%0d S=%h Cout=%b ovf=%b, required lat=8 S=%h Cout=%b ovf=%b",
                     cyc, s_w[1], cout_w[1], ovf_w[1], e.s, e.c, e.o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_chunk();
        vec_t v [3] = '{'{1'b0, 1'b0, 8'h7F, 8'h01}, '{1'b1, 1'b0, 8'h03, 8'h09},
                        '{1'b0, 1'b1, 8'hC3, 8'h5A}};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 3; i++) begin
            issue(2, v[i].m, v[i].ci, v[i].a, v[i].b);
            wait_done(2, cyc);
            e = sb.pop_front();
            checks++;
            if (cyc != nch_of[2] || {s_w[2], cout_w[2], ovf_w[2]} !== {e.s, e.c, e.o}) begin
                errors++;
                $display("FAIL chunk8[%0d] lat=%0d S=%h Cout=%b ovf=%b, required lat=1 S=%h Cout=%b ovf=%b",
                         i, cyc, s_w[2], cout_w[2], ovf_w[2], e.s, e.c, e.o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_hold();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_single_chunk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
